// File: rtl/regfile_write_ctrl.sv
// Round-robin write-port arbiter and clear sequencer for the 8x8 register file.
// Optional macro REGFILE_WCTRL_R0_ZERO_EN: requester writes to address 0 handshake but are dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ARB   | arbitrate requesters onto the write port, one transfer/cycle
// ST_CLEAR | write zero to every address, one per cycle, requesters stalled
module regfile_write_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_start,
   input  logic                      hold,
   output logic                      we,
   output logic [ADDR_W-1:0]         w_addr,
   output logic [DATA_W-1:0]         w_data,
   output logic                      busy,
   output logic                      clear_done
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {ST_ARB, ST_CLEAR} state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt, gnt_idx, cand;
   logic [ADDR_W-1:0]   cnt, cnt_nxt, sel_addr, w_addr_nxt;
   logic [DATA_W-1:0]   sel_data, w_data_nxt;
   logic                gnt_found, we_nxt, done_nxt;
   logic [NUM_REQ-1:0]  grant;

   // First valid requester at or after the pointer, wrapping; clear_start outranks any grant.
   always_comb begin
      grant     = '0;
      gnt_idx   = '0;
      cand      = '0;
      gnt_found = 1'b0;
      if (rst_n && state == ST_ARB && !clear_start && !hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
      if (gnt_found) grant[gnt_idx] = 1'b1;
   end

   assign req_ready = grant;
   assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];
   assign busy      = (state == ST_CLEAR);

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      we_nxt     = 1'b0;
      w_addr_nxt = w_addr;
      w_data_nxt = w_data;
      done_nxt   = 1'b0;
      case (state)
         ST_ARB: begin
            if (clear_start) begin
               state_nxt = ST_CLEAR;
            end else if (gnt_found) begin
               ptr_nxt    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               w_addr_nxt = sel_addr;
               w_data_nxt = sel_data;
`ifdef REGFILE_WCTRL_R0_ZERO_EN
               we_nxt     = (sel_addr != '0);
`else
               we_nxt     = 1'b1;
`endif
            end
         end
         ST_CLEAR: begin
            we_nxt     = 1'b1;
            w_addr_nxt = cnt;
            w_data_nxt = '0;
            cnt_nxt    = cnt + 1'b1;
            // Last address issued: counter wraps to zero and arbitration resumes.
            if (cnt == '1) begin
               state_nxt = ST_ARB;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_ARB;
         ptr        <= '0;
         cnt        <= '0;
         we         <= 1'b0;
         w_addr     <= '0;
         w_data     <= '0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         we         <= we_nxt;
         w_addr     <= w_addr_nxt;
         w_data     <= w_data_nxt;
         clear_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: a grant/clear model predicts writes into a queue,
// a monitor pops and compares whenever the register-file port is written.
module tb_regfile_write_ctrl;

   localparam int NR = 4;
   localparam int AW = 3;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic             clear_start = 1'b0;
   logic             hold = 1'b0;
   logic [NR-1:0]    req_ready;
   logic             we;
   logic [AW-1:0]    w_addr;
   logic [DW-1:0]    w_data;
   logic             busy;
   logic             clear_done;

   regfile_write_ctrl #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
      .hold(hold), .we(we), .w_addr(w_addr), .w_data(w_data), .busy(busy),
      .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            stamp;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            done;
   } wr_t;

   wr_t expq[$];

   // reference state: round-robin pointer and the cycle window in which a clear runs
   int m_ptr = 0;
   int clr_begin = -10;
   int clr_end = -20;

   // monitor: sampled 2 time units after the rising edge
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #2;
         if (we) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%02h", cyc, w_addr, w_data);
            end else begin
               e = expq.pop_front();
               if (e.stamp != cyc || w_addr !== e.addr || w_data !== e.data || clear_done !== e.done) begin
                  errors++;
                  $display("FAIL write cyc=%0d got addr=%0d data=%02h done=%0b expected cyc=%0d addr=%0d data=%02h done=%0b",
                           cyc, w_addr, w_data, clear_done, e.stamp, e.addr, e.data, e.done);
               end
            end
         end else begin
            checks++;
            if (clear_done !== 1'b0) begin
               errors++;
               $display("FAIL clear_done_without_write cyc=%0d got %0b expected 0", cyc, clear_done);
            end
            if (expq.size() > 0 && expq[0].stamp <= cyc) begin
               e = expq.pop_front();
               errors++;
               $display("FAIL missing_write cyc=%0d got we=0 expected addr=%0d data=%02h", cyc, e.addr, e.data);
            end
         end
      end
   end

   // One cycle: check combinational outputs against the model, predict writes, advance model.
   task automatic tick(output int g);
      int            n;
      int            idx;
      bit            exp_busy;
      bit            keep;
      logic [NR-1:0] exp_rdy;
      wr_t           e;
      #1;
      n = cyc;
      exp_busy = (n >= clr_begin && n <= clr_end);
      g = -1;
      if (rst_n && !exp_busy && !clear_start && !hold) begin
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL req_ready cyc=%0d got %b expected %b", n, req_ready, exp_rdy);
      end
      checks++;
      if (busy !== exp_busy) begin
         errors++;
         $display("FAIL busy cyc=%0d got %0b expected %0b", n, busy, exp_busy);
      end
      if (!rst_n) begin
         expq.delete();
         m_ptr = 0;
         if (clr_end >= n) clr_end = n;
      end else if (!exp_busy && clear_start) begin
         clr_begin = n + 1;
         clr_end   = n + 8;
         for (int a = 0; a < 8; a++) begin
            e.stamp = n + 2 + a;
            e.addr  = AW'(a);
            e.data  = '0;
            e.done  = (a == 7);
            expq.push_back(e);
         end
      end else if (g >= 0) begin
         m_ptr = (g + 1) % NR;
         e.stamp = n + 1;
         e.addr  = req_addr[g*AW +: AW];
         e.data  = req_data[g*DW +: DW];
         e.done  = 1'b0;
         keep = 1'b1;
`ifdef REGFILE_WCTRL_R0_ZERO_EN
         if (e.addr == '0) keep = 1'b0;
`endif
         if (keep) expq.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      req_valid = '1;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = AW'(i + 1);
         req_data[i*DW +: DW] = DW'(8'hA0 + i);
      end
      @(negedge clk);

      // reset with all requesters asking, then round robin 0,1,2,3,0
      tick(g); tick(g);
      rst_n = 1'b1;
      for (int r = 0; r < 5; r++) tick(g);

      // single requester blocked by hold, then granted
      req_valid = 4'b0100;
      hold = 1'b1;
      repeat (3) tick(g);
      hold = 1'b0;
      tick(g);
      req_valid = '0;
      tick(g);

      // clear with two requesters waiting; requester 0 first afterwards
      req_valid = 4'b0011;
      clear_start = 1'b1;
      tick(g);
      clear_start = 1'b0;
      for (int r = 0; r < 12; r++) begin
         tick(g);
         if (g >= 0) req_valid[g] = 1'b0;
      end

      // reset part-way through a clear, then a full clear from address 0
      clear_start = 1'b1;
      tick(g);
      clear_start = 1'b0;
      repeat (3) tick(g);
      rst_n = 1'b0;
      tick(g);
      rst_n = 1'b1;
      tick(g);
      clear_start = 1'b1;
      tick(g);
      clear_start = 1'b0;
      repeat (10) tick(g);

      // randomized traffic; requesters hold their request until granted
      for (int c = 0; c < 3000; c++) begin
         hold        = ($urandom_range(0, 5) == 0);
         clear_start = ($urandom_range(0, 40) == 0);
         rst_n       = ($urandom_range(0, 150) != 0);
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
         tick(g);
         if (g >= 0) begin
            req_valid[g] = 1'($urandom_range(0, 1));
            req_addr[g*AW +: AW] = AW'($urandom_range(0, 7));
            req_data[g*DW +: DW] = DW'($urandom);
         end
      end

      // drain
      hold = 1'b0;
      clear_start = 1'b0;
      rst_n = 1'b1;
      req_valid = '0;
      repeat (12) tick(g);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending writes expected 0", expq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
